// File: rtl/seq_braun_multiplier.sv
// Sequential shift-and-add multiplier: one partial-product row per cycle,
// sign handled by magnitude capture and a final conditional negation.
module seq_braun_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    mag_a_sh;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_sum;
  logic             neg;
  logic [CNT_W-1:0] cnt;
  logic             last_row;

  // -2^(WIDTH-1) negates to 2^(WIDTH-1), which still fits as an unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic                    en);
    logic signed [WIDTH-1:0] nx;
    nx = -x;
    return (en && x[WIDTH-1]) ? nx : x;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] x, input logic n);
    return n ? (~x + PW'(1)) : x;
  endfunction

  assign last_row = (cnt == LAST_ROW);
  assign acc_sum  = acc + (mag_b[0] ? mag_a_sh : '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last_row) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Multiplicand shifts left and multiplier right, so row i always uses bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a_sh <= '0;
      mag_b    <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      p        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a_sh <= PW'(magnitude(a, signed_mode));
            mag_b    <= magnitude(b, signed_mode);
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        BUSY: begin
          acc      <= acc_sum;
          mag_a_sh <= mag_a_sh << 1;
          mag_b    <= mag_b >> 1;
          cnt      <= cnt + CNT_W'(1);
          if (last_row) p <= apply_sign(acc_sum, neg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_braun_multiplier.sv
// Directed bench for seq_braun_multiplier at WIDTH=8 plus an exhaustive WIDTH=4 sweep.
module tb_seq_braun_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int n_checks = 0;
  int n_pass   = 0;

  seq_braun_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  seq_braun_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
    .out_ready(out_ready4), .p(p4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Called #1 after an edge with the DUT idle; returns product and edges to out_valid.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                      output logic [15:0] pv, output int lat);
    a8 = av; b8 = bv; sm8 = sm; out_ready8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid8) begin lat = k; break; end
    end
    pv = p8;
    @(posedge clk); #1;
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic sm,
                      output logic [7:0] pv, output int lat);
    a4 = av; b4 = bv; sm4 = sm; out_ready4 = 1'b1; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid4) begin lat = k; break; end
    end
    pv = p4;
    @(posedge clk); #1;
  endtask

  logic [15:0] pv8;
  logic [7:0]  pv4;
  int          lat;
  int          cnt_ov;
  int          acc_e[$];
  int          res_e[$];
  logic        prev_busy, prev_ov;

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready8, 1'b1);
    check("rst_out_valid", out_valid8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_p", p8, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    run8(8'hFF, 8'hFF, 1'b0, pv8, lat);
    check("u_ff_ff_p", pv8, 16'hFE01);
    check("u_ff_ff_lat", lat, 8);
    run8(8'h80, 8'h80, 1'b1, pv8, lat);
    check("s_80_80", pv8, 16'h4000);
    run8(8'hFF, 8'h01, 1'b1, pv8, lat);
    check("s_ff_01", pv8, 16'hFFFF);
    run8(8'h80, 8'h7F, 1'b1, pv8, lat);
    check("s_80_7f", pv8, 16'hC080);
    run8(8'h00, 8'h80, 1'b1, pv8, lat);
    check("s_00_80", pv8, 16'h0000);
    check("s_00_80_lat", lat, 8);
    run8(8'h00, 8'hAB, 1'b0, pv8, lat);
    check("u_zero_lat", lat, 8);
    run8(8'h80, 8'h80, 1'b0, pv8, lat);
    check("u_80_80", pv8, 16'h4000);
    run8(8'hF6, 8'h07, 1'b1, pv8, lat);
    check("s_m10_7", pv8, 16'hFFBA);

    // Stall in DONE with fresh operands offered
    a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; out_ready8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid8) begin lat = k; break; end
    end
    check("stall_lat", lat, 8);
    a8 = 8'h55; b8 = 8'h66; in_valid8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_p", p8, 16'h03A8);
      check("stall_in_ready", in_ready8, 1'b0);
      check("stall_out_valid", out_valid8, 1'b1);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("stall_release", out_valid8, 1'b0);
    cnt_ov = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid8) cnt_ov++;
    end
    check("stall_single", cnt_ov, 0);

    // Abort three cycles into BUSY; rst beats a concurrent in_valid
    a8 = 8'hAB; b8 = 8'hCD; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; in_valid8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    @(posedge clk); #1;
    check("abort_in_ready", in_ready8, 1'b1);
    check("abort_out_valid", out_valid8, 1'b0);
    check("abort_busy", busy8, 1'b0);
    check("abort_p", p8, 16'h0000);
    rst = 1'b0; in_valid8 = 1'b0;
    cnt_ov = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid8) cnt_ov++;
    end
    check("abort_no_output", cnt_ov, 0);
    run8(8'd3, 8'd5, 1'b0, pv8, lat);
    check("after_abort_p", pv8, 16'h000F);
    check("after_abort_lat", lat, 8);

    // Back-to-back throughput
    a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; out_ready8 = 1'b1; in_valid8 = 1'b1;
    prev_busy = busy8; prev_ov = out_valid8;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (busy8 && !prev_busy) acc_e.push_back(e);
      if (out_valid8 && !prev_ov) begin
        res_e.push_back(e);
        check("b2b_p", p8, 16'h03A8);
      end
      prev_busy = busy8; prev_ov = out_valid8;
    end
    in_valid8 = 1'b0;
    check("b2b_n_acc", acc_e.size(), 3);
    check("b2b_n_res", res_e.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < acc_e.size()) check("b2b_acc_edge", acc_e[i], 10 * i);
      if (i < res_e.size()) check("b2b_res_edge", res_e[i], 10 * i + 8);
    end
    @(posedge clk); #1;

    // WIDTH=4 exhaustive sweep against the integer product
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          int x, y;
          logic [31:0] pr;
          x = i; y = j;
          if (m == 1 && i >= 8) x = x - 16;
          if (m == 1 && j >= 8) y = y - 16;
          pr = x * y;
          run4(i[3:0], j[3:0], m[0], pv4, lat);
          check(m ? "w4_signed" : "w4_unsigned", pv4, pr[7:0]);
          if (i == j) check("w4_lat", lat, 4);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
